predictor_update_sequencer: RTL and testbench
=============================================

Name: predictor_update_sequencer

Overview:
- Collects branch-resolution predictor updates from two execute-side requesters.
- Round-robin arbitrates them into a 4-entry FIFO, then drains one update at a time into the BTB write port and the gshare counter table.
- Performs the gshare 2-bit counter read-modify-write and owns the global history register (GHR) used by the update path.
- Sits between the execute/commit stage and the IF-stage predictor arrays.

Parameters:
PC_BITS, 32, program counter width
BTB_SIZE, 256, BTB entries; BTB_IDX_BITS = log2(BTB_SIZE)
GSH_SIZE, 256, gshare counters; GSH_IDX_BITS = log2(GSH_SIZE)
GSH_HISTORY_BITS, 2, GHR width (must be <= GSH_IDX_BITS)
FIFO_DEPTH, 4, update queue depth (power of 2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  2  update valid, one bit per requester
req_ready_o  out  2  update accepted when valid&ready at a rising edge
req_upd_i  in  2x72  predictor_update struct per requester: valid_jump, orig_pc[31:0], jump_address[31:0], jump_taken, is_comp, rat_id[1:0], ticket[2:0]
flush_i  in  1  discard all queued and in-flight updates
btb_wr_en_o  out  1  BTB write strobe
btb_wr_idx_o  out  BTB_IDX_BITS  BTB write index
btb_wr_orig_pc_o  out  PC_BITS  tag written to the BTB
btb_wr_target_o  out  PC_BITS  target written to the BTB
gsh_rd_en_o  out  1  gshare counter read strobe; data returned next cycle
gsh_rd_idx_o  out  GSH_IDX_BITS  read index
gsh_rd_data_i  in  2  counter value, valid the cycle after gsh_rd_en_o
gsh_wr_en_o  out  1  gshare counter write strobe
gsh_wr_idx_o  out  GSH_IDX_BITS  write index
gsh_wr_data_o  out  2  new counter value
ghr_o  out  GSH_HISTORY_BITS  current global history
fifo_count_o  out  3  queued entries (0..4)
busy_o  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (asynchronous): FIFO empty, RR pointer = 0, FSM = IDLE, GHR = 0, held update cleared.
  - All strobes = 0, fifo_count_o = 0, busy_o = 0.
  - Index, data, pc and target outputs = 0.
- Arbitration: at most one push per cycle. Define full = (count == FIFO_DEPTH).
  - req_ready_o[i] = !full && !flush_i && (rr_ptr == i || !req_valid_i[1-i]).
  - After each accepted push, rr_ptr <= index of the granted requester XOR 1.
  - No push while full, even if a pop occurs in the same cycle.
- Indexing:
  - btb idx = orig_pc[BTB_IDX_BITS:1].
  - gsh idx = orig_pc[GSH_IDX_BITS:1] XOR zero-extend(GHR).
- FSM states: IDLE, RMW.
  - IDLE, FIFO non-empty, head.valid_jump = 0: pop and discard. No strobes, stay IDLE.
  - IDLE, FIFO non-empty, head.valid_jump = 1: pop into the hold register, assert gsh_rd_en_o with gsh_rd_idx_o computed from the head and current GHR (combinational), go to RMW.
  - RMW: sample gsh_rd_data_i.
    - New counter = taken ? min(c+1, 3) : max(c-1, 0).
    - Assert gsh_wr_en_o at the same index. Assert btb_wr_en_o only if jump_taken, with target = jump_address.
    - GHR <= {GHR[GSH_HISTORY_BITS-2:0], jump_taken}.
    - Go to IDLE. No pop occurs in RMW.
- Throughput and latency:
  - One valid_jump update every 2 cycles; one discard per cycle.
  - Request accepted at edge T: earliest pop in cycle T+1, writes in cycle T+2.
- Flush:
  - Clears the FIFO at the next edge; any pop in that cycle is cancelled.
  - All ready outputs are 0 during flush.
  - In RMW: gsh and btb writes are suppressed, GHR is unchanged, go to IDLE.
  - In IDLE: gsh_rd_en_o is still allowed combinationally but is ignored (state stays IDLE).
  - GHR is never cleared by flush.
- Ordering: drained updates retain acceptance order; per-index RMW hazards cannot occur because updates are serialized.
- Reset asserted mid-RMW: all state returns to reset values immediately; no write is issued.

Test Plan:
1. Single update, req0 {valid_jump=1, orig_pc=0x104, target=0x200, taken=1}, counter read = 1 → cycle T+1: gsh_rd_idx = 0x82. Cycle T+2: gsh_wr_data = 2, btb_wr_idx = 0x82, target = 0x200. Then GHR = 01.
2. Saturation: taken with counter 3 → writes 3. Not-taken with counter 0 → writes 0, btb_wr_en_o stays 0.
3. Both requesters valid every cycle from reset → grants alternate 0,1,0,1. FIFO fills to 4, then ready = 00 until a pop. Drain order equals grant order.
4. valid_jump = 0 entries: push 3 of them → drained in 3 consecutive cycles with no strobes; fifo_count_o goes 3 → 0.
5. Flush during RMW with 2 queued entries → no write that cycle, fifo_count_o = 0 next cycle, GHR unchanged, busy_o = 0.
6. GHR hashing: GHR = 11, orig_pc = 0x104 → gsh_rd_idx = 0x81. Assert rst_n low mid-RMW → no write issued, GHR = 0, all outputs return to reset values.

Source files
------------

// File: rtl/predictor_update_sequencer.sv
// Predictor update sequencer: round-robin merges two branch-resolution streams into a small
// queue, then drains each entry into a BTB write and a gshare 2-bit counter read-modify-write.
//
// state | meaning
// IDLE  | head of queue is examined; no-jump entries are discarded, jumps start a counter read
// RMW   | counter read data returns; counter, BTB and GHR are updated from the held entry
module predictor_update_sequencer #(
    parameter int PC_BITS          = 32,
    parameter int BTB_SIZE         = 256,
    parameter int GSH_SIZE         = 256,
    parameter int GSH_HISTORY_BITS = 2,
    parameter int FIFO_DEPTH       = 4,
    localparam int BTB_IDX_BITS    = $clog2(BTB_SIZE),
    localparam int GSH_IDX_BITS    = $clog2(GSH_SIZE),
    localparam int CNT_BITS        = $clog2(FIFO_DEPTH) + 1,
    localparam int UPD_BITS        = 2 * PC_BITS + 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [1:0]                       req_valid_i,
    output logic [1:0]                       req_ready_o,
    input  logic [1:0][UPD_BITS-1:0]         req_upd_i,
    input  logic                             flush_i,
    output logic                             btb_wr_en_o,
    output logic [BTB_IDX_BITS-1:0]          btb_wr_idx_o,
    output logic [PC_BITS-1:0]               btb_wr_orig_pc_o,
    output logic [PC_BITS-1:0]               btb_wr_target_o,
    output logic                             gsh_rd_en_o,
    output logic [GSH_IDX_BITS-1:0]          gsh_rd_idx_o,
    input  logic [1:0]                       gsh_rd_data_i,
    output logic                             gsh_wr_en_o,
    output logic [GSH_IDX_BITS-1:0]          gsh_wr_idx_o,
    output logic [1:0]                       gsh_wr_data_o,
    output logic [GSH_HISTORY_BITS-1:0]      ghr_o,
    output logic [CNT_BITS-1:0]              fifo_count_o,
    output logic                             busy_o
);

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, RMW} state_t;

    // Only the fields the update path consumes are queued.
    typedef struct packed {
        logic               valid_jump;
        logic [PC_BITS-1:0] orig_pc;
        logic [PC_BITS-1:0] jump_address;
        logic               jump_taken;
    } entry_t;

    function automatic entry_t decode_upd(input logic [UPD_BITS-1:0] upd);
        entry_t e;
        e.valid_jump   = upd[UPD_BITS-1];
        e.orig_pc      = upd[UPD_BITS-2 -: PC_BITS];
        e.jump_address = upd[PC_BITS+6 -: PC_BITS];
        e.jump_taken   = upd[6];
        return e;
    endfunction

    entry_t                      fifo_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]         wr_ptr;
    logic [PTR_BITS-1:0]         rd_ptr;
    logic [CNT_BITS-1:0]         count;
    logic                        rr_ptr;
    state_t                      state;
    logic [GSH_HISTORY_BITS-1:0] ghr;
    logic [PC_BITS-1:0]          hold_pc;
    logic [PC_BITS-1:0]          hold_target;
    logic                        hold_taken;
    logic [GSH_IDX_BITS-1:0]     hold_gsh_idx;

    logic                        full;
    logic                        empty;
    logic [1:0]                  ready;
    logic                        grant_idx;
    logic                        push;
    logic                        pop;
    logic                        rd_en;
    logic                        wr_en;
    logic                        btb_en;
    entry_t                      push_entry;
    entry_t                      head;
    logic [GSH_IDX_BITS-1:0]     head_gsh_idx;
    logic [1:0]                  new_ctr;
    logic                        unused_upd_fields;

    assign unused_upd_fields = ^{req_upd_i[0][5:0], req_upd_i[1][5:0]};

    always_comb begin
        full         = (count == CNT_BITS'(FIFO_DEPTH));
        empty        = (count == '0);
        ready[0]     = !full && !flush_i && (rr_ptr == 1'b0 || !req_valid_i[1]);
        ready[1]     = !full && !flush_i && (rr_ptr == 1'b1 || !req_valid_i[0]);
        grant_idx    = req_valid_i[1] && ready[1];
        push         = |(req_valid_i & ready);
        push_entry   = decode_upd(req_upd_i[grant_idx]);
        head         = fifo_mem[rd_ptr];
        head_gsh_idx = head.orig_pc[GSH_IDX_BITS:1] ^ GSH_IDX_BITS'(ghr);
        // The read strobe may fire during a flush; the state machine simply ignores it.
        rd_en        = (state == IDLE) && !empty && head.valid_jump;
        pop          = (state == IDLE) && !empty && !flush_i;
        wr_en        = (state == RMW) && !flush_i;
        btb_en       = wr_en && hold_taken;
        if (hold_taken) begin
            new_ctr = (gsh_rd_data_i == 2'b11) ? 2'b11 : gsh_rd_data_i + 2'b01;
        end else begin
            new_ctr = (gsh_rd_data_i == 2'b00) ? 2'b00 : gsh_rd_data_i - 2'b01;
        end
    end

    assign req_ready_o      = ready;
    assign gsh_rd_en_o      = rd_en;
    assign gsh_rd_idx_o     = rd_en ? head_gsh_idx : '0;
    assign gsh_wr_en_o      = wr_en;
    assign gsh_wr_idx_o     = wr_en ? hold_gsh_idx : '0;
    assign gsh_wr_data_o    = wr_en ? new_ctr : 2'b00;
    assign btb_wr_en_o      = btb_en;
    assign btb_wr_idx_o     = btb_en ? hold_pc[BTB_IDX_BITS:1] : '0;
    assign btb_wr_orig_pc_o = btb_en ? hold_pc : '0;
    assign btb_wr_target_o  = btb_en ? hold_target : '0;
    assign ghr_o            = ghr;
    assign fifo_count_o     = count;
    assign busy_o           = !empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rr_ptr       <= 1'b0;
            state        <= IDLE;
            ghr          <= '0;
            hold_pc      <= '0;
            hold_target  <= '0;
            hold_taken   <= 1'b0;
            hold_gsh_idx <= '0;
        end else begin
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_BITS'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_BITS'(1);
                end
                count <= count + CNT_BITS'(push) - CNT_BITS'(pop);
            end
            if (push) begin
                rr_ptr <= ~grant_idx;
            end
            case (state)
                IDLE: begin
                    if (pop && head.valid_jump) begin
                        hold_pc      <= head.orig_pc;
                        hold_target  <= head.jump_address;
                        hold_taken   <= head.jump_taken;
                        hold_gsh_idx <= head_gsh_idx;
                        state        <= RMW;
                    end
                end
                RMW: begin
                    // Shift in the outcome; the cast keeps the youngest history bits.
                    if (!flush_i) begin
                        ghr <= GSH_HISTORY_BITS'({ghr, hold_taken});
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_predictor_update_sequencer.sv
// Directed bench for predictor_update_sequencer: hand-computed indices, counter values,
// grant order, discard draining, flush and mid-update reset.
module tb_predictor_update_sequencer;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [1:0][71:0]  req_upd = '0;
    logic              flush = 1'b0;
    logic              btb_wr_en;
    logic [7:0]        btb_wr_idx;
    logic [31:0]       btb_wr_orig_pc;
    logic [31:0]       btb_wr_target;
    logic              gsh_rd_en;
    logic [7:0]        gsh_rd_idx;
    logic [1:0]        gsh_rd_data = 2'b00;
    logic              gsh_wr_en;
    logic [7:0]        gsh_wr_idx;
    logic [1:0]        gsh_wr_data;
    logic [1:0]        ghr;
    logic [2:0]        fifo_count;
    logic              busy;

    int checks = 0;
    int failures = 0;

    predictor_update_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_upd_i        (req_upd),
        .flush_i          (flush),
        .btb_wr_en_o      (btb_wr_en),
        .btb_wr_idx_o     (btb_wr_idx),
        .btb_wr_orig_pc_o (btb_wr_orig_pc),
        .btb_wr_target_o  (btb_wr_target),
        .gsh_rd_en_o      (gsh_rd_en),
        .gsh_rd_idx_o     (gsh_rd_idx),
        .gsh_rd_data_i    (gsh_rd_data),
        .gsh_wr_en_o      (gsh_wr_en),
        .gsh_wr_idx_o     (gsh_wr_idx),
        .gsh_wr_data_o    (gsh_wr_data),
        .ghr_o            (ghr),
        .fifo_count_o     (fifo_count),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Side fields (is_comp, rat_id, ticket) are non-zero to show they are ignored.
    function automatic logic [71:0] mk_upd(input logic vj, input logic [31:0] pc,
                                           input logic [31:0] tgt, input logic tk);
        return {vj, pc, tgt, tk, 1'b1, 2'b10, 3'b101};
    endfunction

    // Pushes one jump through requester 0 from an idle, empty sequencer and checks both phases.
    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                             input logic [1:0] cnt, input logic [7:0] exp_idx,
                             input logic [1:0] exp_data, input logic [1:0] exp_ghr);
        req_upd[0]  = mk_upd(1'b1, pc, tgt, tk);
        req_valid   = 2'b01;
        gsh_rd_data = cnt;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("rd_en", gsh_rd_en, 1);
        check("rd_idx", gsh_rd_idx, exp_idx);
        @(posedge clk); #1;
        @(negedge clk);
        check("wr_en", gsh_wr_en, 1);
        check("wr_idx", gsh_wr_idx, exp_idx);
        check("wr_data", gsh_wr_data, exp_data);
        check("btb_en", btb_wr_en, tk);
        if (tk) begin
            check("btb_idx", btb_wr_idx, pc[8:1]);
            check("btb_pc", btb_wr_orig_pc, pc);
            check("btb_tgt", btb_wr_target, tgt);
        end
        @(posedge clk); #1;
        check("ghr", ghr, exp_ghr);
        check("busy_end", busy, 0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [1:0]  exp_rdy [9] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10};
    int          exp_cnt [9] = '{0, 1, 1, 2, 2, 3, 3, 4, 3};
    logic [71:0] t4_list [6];
    logic [71:0] t5_list [4];
    int          n_wr;

    initial begin
        reset_dut();
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_ghr", ghr, 0);
        check("rst_ready", req_ready, 2'b11);
        check("rst_strobes", {btb_wr_en, gsh_rd_en, gsh_wr_en}, 0);
        check("rst_idx", {gsh_rd_idx, gsh_wr_idx, btb_wr_idx}, 0);

        // Single update, then saturation at both ends (GHR 01 -> 11 -> 10).
        do_update(32'h104, 32'h200, 1'b1, 2'd1, 8'h82, 2'd2, 2'b01);
        do_update(32'h104, 32'h240, 1'b1, 2'd3, 8'h83, 2'd3, 2'b11);
        do_update(32'h104, 32'h280, 1'b0, 2'd0, 8'h81, 2'd0, 2'b10);

        // Both requesters valid every cycle from reset: alternating grants, fill to 4, ordered drain.
        reset_dut();
        req_upd[0]  = mk_upd(1'b1, 32'h010, 32'h400, 1'b1);
        req_upd[1]  = mk_upd(1'b1, 32'h020, 32'h500, 1'b1);
        req_valid   = 2'b11;
        gsh_rd_data = 2'd1;
        n_wr = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c < 9) begin
                check($sformatf("rr_ready_c%0d", c), req_ready, exp_rdy[c]);
                check($sformatf("rr_count_c%0d", c), fifo_count, exp_cnt[c]);
            end
            if (btb_wr_en) begin
                check($sformatf("order_w%0d", n_wr), btb_wr_idx, (n_wr % 2 == 0) ? 8'h08 : 8'h10);
                n_wr++;
            end
            @(posedge clk); #1;
            if (c == 8) req_valid = 2'b00;
        end
        check("order_writes", n_wr, 8);
        check("order_ghr", ghr, 2'b11);
        check("order_busy", busy, 0);

        // Three not-taken jumps leave three discards queued (GHR 11 -> 00).
        t4_list[0] = mk_upd(1'b1, 32'h300, 32'h0, 1'b0);
        t4_list[1] = mk_upd(1'b1, 32'h304, 32'h0, 1'b0);
        t4_list[2] = mk_upd(1'b1, 32'h308, 32'h0, 1'b0);
        t4_list[3] = mk_upd(1'b0, 32'h310, 32'h600, 1'b1);
        t4_list[4] = mk_upd(1'b0, 32'h314, 32'h600, 1'b1);
        t4_list[5] = mk_upd(1'b0, 32'h318, 32'h600, 1'b1);
        for (int k = 0; k < 6; k++) begin
            req_upd[0] = t4_list[k];
            req_valid  = 2'b01;
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        @(negedge clk);
        check("disc_count_start", fifo_count, 3);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("disc_count_%0d", j), fifo_count, 3 - j);
            if (j < 3) begin
                check($sformatf("disc_strobes_%0d", j), {btb_wr_en, gsh_rd_en, gsh_wr_en}, 0);
            end
        end
        check("disc_ghr", ghr, 2'b00);

        // Flush while in RMW with two entries queued; first jump already moved GHR to 01.
        t5_list[0] = mk_upd(1'b1, 32'h400, 32'h700, 1'b1);
        t5_list[1] = mk_upd(1'b1, 32'h404, 32'h704, 1'b1);
        t5_list[2] = mk_upd(1'b1, 32'h408, 32'h708, 1'b1);
        t5_list[3] = mk_upd(1'b1, 32'h40c, 32'h70c, 1'b1);
        for (int k = 0; k < 4; k++) begin
            req_upd[0] = t5_list[k];
            req_valid  = 2'b01;
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        flush     = 1'b1;
        @(negedge clk);
        check("flush_count_pre", fifo_count, 2);
        check("flush_no_wr", {gsh_wr_en, btb_wr_en}, 0);
        check("flush_ready", req_ready, 2'b00);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_count", fifo_count, 0);
        check("flush_busy", busy, 0);
        check("flush_ghr", ghr, 2'b01);

        // Bring GHR to 11, hash check, then reset in the middle of the RMW.
        do_update(32'h104, 32'h200, 1'b1, 2'd1, 8'h83, 2'd2, 2'b11);
        req_upd[0]  = mk_upd(1'b1, 32'h104, 32'h300, 1'b1);
        req_valid   = 2'b01;
        gsh_rd_data = 2'd2;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("hash_rd_idx", gsh_rd_idx, 8'h81);
        @(posedge clk); #1;
        check("rmw_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_rmw_strobes", {btb_wr_en, gsh_rd_en, gsh_wr_en}, 0);
        check("rst_rmw_data", {gsh_wr_idx, gsh_wr_data, btb_wr_idx}, 0);
        check("rst_rmw_target", btb_wr_target, 0);
        check("rst_rmw_ghr", ghr, 0);
        check("rst_rmw_busy", {busy, fifo_count}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", req_ready, 2'b11);
        check("post_rst_wr", gsh_wr_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
